// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants, used by the fetch/decode queue and by later stages.
package fetch_pkg;

  localparam int unsigned FDQ_DEFAULT_DEPTH = 4;
  localparam int unsigned SEQ_NUM_BITS      = 5;

  typedef struct packed {
    logic [31:0]             inst;
    logic [31:0]             pc;
    logic [SEQ_NUM_BITS-1:0] seq_num;
  } fdq_entry_t;

endpackage

// File: rtl/fdq_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the fetch/decode queue, including squash.
module fdq_ptr_ctrl #(
  parameter int unsigned p_depth = 4,
  localparam int unsigned PtrW   = $clog2(p_depth),
  localparam int unsigned CntW   = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq,
  input  logic            deq,
  input  logic            squash,
  output logic [PtrW-1:0] head,
  output logic [PtrW-1:0] tail,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (squash) begin
      // Drop everything by collapsing head onto tail; the tail itself never moves on squash.
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PtrW'(1);
      if (deq) head_d = head_q + PtrW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;
  assign full  = (count_q == CntW'(p_depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction buffer with sequence-number tagging and squash.
// Define FETCH_DECODE_QUEUE_BYPASS_EN for a zero-latency path when the queue is empty.
module fetch_decode_queue
  import fetch_pkg::*;
#(
  parameter int unsigned p_depth        = FDQ_DEFAULT_DEPTH,
  parameter int unsigned p_seq_num_bits = SEQ_NUM_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      f_val,
  output logic                      f_rdy,
  input  logic [31:0]               f_inst,
  input  logic [31:0]               f_pc,
  output logic                      d_val,
  input  logic                      d_rdy,
  output logic [31:0]               d_inst,
  output logic [31:0]               d_pc,
  output logic [p_seq_num_bits-1:0] d_seq_num,
  input  logic                      squash
);

  localparam int unsigned PtrW = $clog2(p_depth);

  logic [PtrW-1:0]           head, tail;
  logic [PtrW:0]             count;
  logic                      full, empty;
  logic                      enq, deq, bypass_take;
  logic [p_seq_num_bits-1:0] seq_ctr_q;

  logic [31:0]               inst_mem [p_depth];
  logic [31:0]               pc_mem   [p_depth];
  logic [p_seq_num_bits-1:0] seq_mem  [p_depth];

  assign f_rdy = ~full & ~squash;

`ifdef FETCH_DECODE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass      = empty & ~squash;
  assign bypass_take = bypass & f_val & d_rdy;
  assign d_val       = bypass ? f_val  : ~empty;
  assign d_inst      = bypass ? f_inst : inst_mem[head];
  assign d_pc        = bypass ? f_pc   : pc_mem[head];
  assign d_seq_num   = bypass ? seq_ctr_q : seq_mem[head];
`else
  assign bypass_take = 1'b0;
  assign d_val       = ~empty;
  assign d_inst      = inst_mem[head];
  assign d_pc        = pc_mem[head];
  assign d_seq_num   = seq_mem[head];
`endif

  // A bypassed instruction is consumed directly and never occupies a slot.
  assign enq = f_val & f_rdy & ~bypass_take;
  assign deq = d_val & d_rdy & ~empty;

  fdq_ptr_ctrl #(
    .p_depth (p_depth)
  ) u_ptr_ctrl (
    .clk    (clk),
    .rst    (rst),
    .enq    (enq),
    .deq    (deq),
    .squash (squash),
    .head   (head),
    .tail   (tail),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[tail] <= f_inst;
      pc_mem[tail]   <= f_pc;
      seq_mem[tail]  <= seq_ctr_q;
    end
  end

  // Counts every accepted instruction, bypassed or not; squash leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_ctr_q <= '0;
    end else if (f_val & f_rdy) begin
      seq_ctr_q <= seq_ctr_q + p_seq_num_bits'(1);
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed vector table plus streaming/bypass sequences.
module tb_fetch_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_val, f_rdy, d_val, d_rdy, squash;
  logic [31:0] f_inst, f_pc, d_inst, d_pc;
  logic [4:0]  d_seq_num;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_decode_queue #(
    .p_depth        (4),
    .p_seq_num_bits (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .f_val     (f_val),
    .f_rdy     (f_rdy),
    .f_inst    (f_inst),
    .f_pc      (f_pc),
    .d_val     (d_val),
    .d_rdy     (d_rdy),
    .d_inst    (d_inst),
    .d_pc      (d_pc),
    .d_seq_num (d_seq_num),
    .squash    (squash)
  );

  typedef struct {
    logic        rst;
    logic        f_val;
    logic [31:0] pc;
    logic        d_rdy;
    logic        squash;
    logic        e_f_rdy;
    logic        e_d_val;
    logic [31:0] e_pc;
    logic [4:0]  e_seq;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fv, input logic [31:0] pc, input logic dr,
                       input logic sq);
    rst    = r;
    f_val  = fv;
    f_pc   = pc;
    f_inst = inst_of(pc);
    d_rdy  = dr;
    squash = sq;
  endtask

  task automatic add(input logic r, input logic fv, input logic [31:0] pc, input logic dr,
                     input logic sq, input logic efr, input logic edv, input logic [31:0] epc,
                     input logic [4:0] eseq);
    vec_t v;
    v.rst = r; v.f_val = fv; v.pc = pc; v.d_rdy = dr; v.squash = sq;
    v.e_f_rdy = efr; v.e_d_val = edv; v.e_pc = epc; v.e_seq = eseq;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    do_reset();

`ifndef FETCH_DECODE_QUEUE_BYPASS_EN
    // rst fv pc dr sq | f_rdy d_val d_pc seq
    add(0, 0, 32'h000, 0, 0, 1, 0, 32'h000, 0);   // reset state
    add(0, 1, 32'h200, 0, 0, 1, 0, 32'h000, 0);   // fill 4, decode stalled
    add(0, 1, 32'h204, 0, 0, 1, 1, 32'h200, 0);
    add(0, 1, 32'h208, 0, 0, 1, 1, 32'h200, 0);
    add(0, 1, 32'h20C, 0, 0, 1, 1, 32'h200, 0);
    add(0, 1, 32'h210, 0, 0, 0, 1, 32'h200, 0);   // full, refused
    add(0, 0, 32'h000, 1, 0, 0, 1, 32'h200, 0);   // drain in order
    add(0, 0, 32'h000, 1, 0, 1, 1, 32'h204, 1);
    add(0, 0, 32'h000, 1, 0, 1, 1, 32'h208, 2);
    add(0, 0, 32'h000, 1, 0, 1, 1, 32'h20C, 3);
    add(0, 0, 32'h000, 1, 0, 1, 0, 32'h000, 0);
    add(0, 1, 32'h400, 0, 0, 1, 0, 32'h000, 0);   // refill to full
    add(0, 1, 32'h404, 0, 0, 1, 1, 32'h400, 4);
    add(0, 1, 32'h408, 0, 0, 1, 1, 32'h400, 4);
    add(0, 1, 32'h40C, 0, 0, 1, 1, 32'h400, 4);
    add(0, 1, 32'h410, 1, 0, 0, 1, 32'h400, 4);   // full + deq: deq only
    add(0, 1, 32'h410, 0, 0, 1, 1, 32'h404, 5);   // freed slot accepted now
    add(0, 0, 32'h000, 1, 0, 0, 1, 32'h404, 5);
    add(0, 0, 32'h000, 1, 0, 1, 1, 32'h408, 6);
    add(0, 0, 32'h000, 1, 0, 1, 1, 32'h40C, 7);
    add(0, 0, 32'h000, 1, 0, 1, 1, 32'h410, 8);
    add(0, 0, 32'h000, 1, 0, 1, 0, 32'h000, 0);
    add(0, 1, 32'h500, 0, 0, 1, 0, 32'h000, 0);   // 3 entries then squash
    add(0, 1, 32'h504, 0, 0, 1, 1, 32'h500, 9);
    add(0, 1, 32'h508, 0, 0, 1, 1, 32'h500, 9);
    add(0, 1, 32'h50C, 0, 1, 0, 1, 32'h500, 9);
    add(0, 1, 32'h600, 0, 0, 1, 0, 32'h000, 0);
    add(0, 0, 32'h000, 1, 0, 1, 1, 32'h600, 12);  // numbering continues
    add(0, 0, 32'h000, 0, 0, 1, 0, 32'h000, 0);
    add(0, 1, 32'h700, 0, 0, 1, 0, 32'h000, 0);   // 2 entries then reset
    add(0, 1, 32'h704, 0, 0, 1, 1, 32'h700, 13);
    add(1, 0, 32'h000, 0, 0, 1, 1, 32'h700, 13);
    add(0, 0, 32'h000, 0, 0, 1, 0, 32'h000, 0);
    add(0, 1, 32'h800, 0, 0, 1, 0, 32'h000, 0);
    add(0, 0, 32'h000, 1, 0, 1, 1, 32'h800, 0);   // seq restarts at 0
    add(0, 0, 32'h000, 0, 0, 1, 0, 32'h000, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].f_val, vecs[i].pc, vecs[i].d_rdy, vecs[i].squash);
      #4;
      check($sformatf("v%0d_f_rdy", i), 32'(f_rdy), 32'(vecs[i].e_f_rdy));
      check($sformatf("v%0d_d_val", i), 32'(d_val), 32'(vecs[i].e_d_val));
      if (vecs[i].e_d_val) begin
        check($sformatf("v%0d_d_pc", i), d_pc, vecs[i].e_pc);
        check($sformatf("v%0d_d_inst", i), d_inst, inst_of(vecs[i].e_pc));
        check($sformatf("v%0d_d_seq", i), 32'(d_seq_num), 32'(vecs[i].e_seq));
      end
      @(posedge clk);
      #1;
    end

    // Streaming: one per cycle after the first, sequence number wraps at the 33rd.
    begin
      logic [31:0] q_pc[$];
      logic [4:0]  q_seq[$];
      logic [4:0]  seq_m;
      int          n_deq;
      do_reset();
      seq_m = '0;
      n_deq = 0;
      for (int i = 0; i < 40; i++) begin
        drive(1'b0, 1'b1, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);
        #4;
        check($sformatf("s%0d_f_rdy", i), 32'(f_rdy), 32'd1);
        check($sformatf("s%0d_d_val", i), 32'(d_val), 32'(q_pc.size() != 0));
        if (d_val && q_pc.size() != 0) begin
          check($sformatf("s%0d_d_pc", i), d_pc, q_pc[0]);
          check($sformatf("s%0d_d_seq", i), 32'(d_seq_num), 32'(q_seq[0]));
          if (n_deq == 32) check("stream_wrap_seq", 32'(d_seq_num), 32'd0);
          void'(q_pc.pop_front());
          void'(q_seq.pop_front());
          n_deq++;
        end
        if (f_rdy) begin
          q_pc.push_back(f_pc);
          q_seq.push_back(seq_m);
          seq_m = seq_m + 5'd1;
        end
        @(posedge clk);
        #1;
      end
      check("stream_deq_total", 32'(n_deq), 32'd39);
    end
`else
    // Bypass: empty queue with decode ready consumes the instruction in the same cycle.
    drive(1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
    #4;
    check("byp_d_val", 32'(d_val), 32'd1);
    check("byp_d_pc", d_pc, 32'h300);
    check("byp_d_inst", d_inst, inst_of(32'h300));
    check("byp_d_seq", 32'(d_seq_num), 32'd0);
    check("byp_f_rdy", 32'(f_rdy), 32'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #4;
    check("byp_empty_after", 32'(d_val), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 32'h304, 1'b0, 1'b0);
    #4;
    check("byp_stall_d_val", 32'(d_val), 32'd1);
    check("byp_stall_d_pc", d_pc, 32'h304);
    check("byp_stall_seq", 32'(d_seq_num), 32'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #4;
    check("byp_held_d_val", 32'(d_val), 32'd1);
    check("byp_held_d_pc", d_pc, 32'h304);
    check("byp_held_seq", 32'(d_seq_num), 32'd1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #4;
    check("byp_drained", 32'(d_val), 32'd0);
    check("byp_drained_f_rdy", 32'(f_rdy), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
